// File: rtl/axi_lite_avalon_bridge_if.sv
// Bundles the AXI4-Lite slave channels and the Avalon-MM master signals of the bridge.
// The slave modport is the bridge's view; the master modport is the interconnect/register-block side.
interface axi_lite_avalon_bridge_if #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int AVS_AW = 11
);
  logic [AW-1:0]     S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DW-1:0]     S_AXI_WDATA;
  logic [DW/8-1:0]   S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [AW-1:0]     S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DW-1:0]     S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic [AVS_AW-1:0] oAvsAddress;
  logic [DW/8-1:0]   oAvsByteenable;
  logic              oAvsRead;
  logic              oAvsWrite;
  logic [DW-1:0]     oAvsWritedata;
  logic [DW-1:0]     iAvsReaddata;
  logic              iAvsWaitrequest;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY,
    output oAvsAddress, oAvsByteenable, oAvsRead, oAvsWrite, oAvsWritedata,
    input  iAvsReaddata, iAvsWaitrequest
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY,
    input  oAvsAddress, oAvsByteenable, oAvsRead, oAvsWrite, oAvsWritedata,
    output iAvsReaddata, iAvsWaitrequest
  );
endinterface

// File: rtl/axi_lite_avalon_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge: window decode, waitrequest timeout,
// alternating read/write arbitration, one transaction in flight.
//
// state   | meaning
// IDLE    | arbitrate; pulse AW/W or AR ready, decode on handshake
// WR_ACC  | oAvsWrite held until waitrequest low or timeout
// RD_ACC  | oAvsRead held until waitrequest low or timeout
// WR_RESP | BVALID held until BREADY
// RD_RESP | RVALID/RDATA held until RREADY
module axi_lite_avalon_bridge #(
  parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR         = 32'h0000_FFFF,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_AVS_ADDR_WIDTH   = 11,
  parameter int          C_TIMEOUT          = 255
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axi_lite_avalon_bridge_if.slave bus
);

  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int VW  = C_AVS_ADDR_WIDTH;
  localparam int LSB = $clog2(SW);
  localparam int TW  = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'((C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0);
  localparam logic [AW:0]   BASE_X   = {1'b0, AW'(C_BASEADDR)};
  localparam logic [AW:0]   HIGH_X   = {1'b0, AW'(C_HIGHADDR)};

  typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;

  state_t          state_q, state_d;
  logic            awready_q, awready_d;
  logic            arready_q, arready_d;
  logic            bvalid_q, bvalid_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [VW-1:0]   avs_addr_q, avs_addr_d;
  logic [SW-1:0]   avs_be_q, avs_be_d;
  logic [DW-1:0]   avs_wdata_q, avs_wdata_d;
  logic            avs_read_q, avs_read_d;
  logic            avs_write_q, avs_write_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            last_wr_q, last_wr_d;

  logic            wr_elig, rd_elig, aw_hs, ar_hs, arbitrate;
  logic [AW-1:0]   dec_addr;
  logic [AW:0]     lo_diff, hi_diff;
  logic            in_win;
  logic [VW-1:0]   avs_off;
  logic            unused_ok;

  assign wr_elig = bus.S_AXI_AWVALID && bus.S_AXI_WVALID;
  assign rd_elig = bus.S_AXI_ARVALID;
  assign aw_hs   = awready_q && wr_elig;
  assign ar_hs   = arready_q && rd_elig;

  // Both ready flops are never high together, so one decoder serves both channels.
  // Sign bits of the widened differences give the window bounds without constant compares.
  assign dec_addr = awready_q ? bus.S_AXI_AWADDR : bus.S_AXI_ARADDR;
  assign lo_diff  = {1'b0, dec_addr} - BASE_X;
  assign hi_diff  = HIGH_X - {1'b0, dec_addr};
  assign in_win   = !lo_diff[AW] && !hi_diff[AW];
  assign avs_off  = {lo_diff[VW-1:LSB], {LSB{1'b0}}};
  assign unused_ok = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT, lo_diff, hi_diff};

  always_comb begin
    state_d     = state_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    avs_addr_d  = avs_addr_q;
    avs_be_d    = avs_be_q;
    avs_wdata_d = avs_wdata_q;
    avs_read_d  = avs_read_q;
    avs_write_d = avs_write_q;
    tmo_d       = tmo_q;
    last_wr_d   = last_wr_q;
    arbitrate   = 1'b0;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          avs_addr_d  = avs_off;
          avs_be_d    = bus.S_AXI_WSTRB;
          avs_wdata_d = bus.S_AXI_WDATA;
          tmo_d       = TMO_LOAD;
          if (!in_win) begin
            bresp_d  = 2'b11;
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end else if (bus.S_AXI_WSTRB == '0) begin
            bresp_d  = 2'b00;
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end else begin
            avs_write_d = 1'b1;
            state_d     = WR_ACC;
          end
        end else if (ar_hs) begin
          avs_addr_d = avs_off;
          avs_be_d   = '1;
          tmo_d      = TMO_LOAD;
          if (!in_win) begin
            rresp_d  = 2'b11;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = RD_RESP;
          end else begin
            avs_read_d = 1'b1;
            state_d    = RD_ACC;
          end
        end else begin
          arbitrate = 1'b1;
        end
      end
      WR_ACC: begin
        if (!bus.iAvsWaitrequest) begin
          avs_write_d = 1'b0;
          bresp_d     = 2'b00;
          bvalid_d    = 1'b1;
          state_d     = WR_RESP;
        end else if ((C_TIMEOUT != 0) && (tmo_q == '0)) begin
          avs_write_d = 1'b0;
          bresp_d     = 2'b10;
          bvalid_d    = 1'b1;
          state_d     = WR_RESP;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      RD_ACC: begin
        if (!bus.iAvsWaitrequest) begin
          avs_read_d = 1'b0;
          rresp_d    = 2'b00;
          rdata_d    = bus.iAvsReaddata;
          rvalid_d   = 1'b1;
          state_d    = RD_RESP;
        end else if ((C_TIMEOUT != 0) && (tmo_q == '0)) begin
          avs_read_d = 1'b0;
          rresp_d    = 2'b10;
          rdata_d    = '0;
          rvalid_d   = 1'b1;
          state_d    = RD_RESP;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      WR_RESP: begin
        if (bus.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          last_wr_d = 1'b1;
          state_d   = IDLE;
          arbitrate = 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          last_wr_d = 1'b0;
          state_d   = IDLE;
          arbitrate = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant decided on the edge that enters (or stays in) IDLE so ready is high the next cycle.
    if (arbitrate) begin
      if (wr_elig && (!rd_elig || !last_wr_d)) begin
        awready_d = 1'b1;
      end else if (rd_elig) begin
        arready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      avs_addr_q  <= '0;
      avs_be_q    <= '0;
      avs_wdata_q <= '0;
      avs_read_q  <= 1'b0;
      avs_write_q <= 1'b0;
      tmo_q       <= '0;
      last_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      avs_addr_q  <= avs_addr_d;
      avs_be_q    <= avs_be_d;
      avs_wdata_q <= avs_wdata_d;
      avs_read_q  <= avs_read_d;
      avs_write_q <= avs_write_d;
      tmo_q       <= tmo_d;
      last_wr_q   <= last_wr_d;
    end
  end

  assign bus.S_AXI_AWREADY  = awready_q;
  assign bus.S_AXI_WREADY   = awready_q;
  assign bus.S_AXI_ARREADY  = arready_q;
  assign bus.S_AXI_BVALID   = bvalid_q;
  assign bus.S_AXI_BRESP    = bresp_q;
  assign bus.S_AXI_RVALID   = rvalid_q;
  assign bus.S_AXI_RRESP    = rresp_q;
  assign bus.S_AXI_RDATA    = rdata_q;
  assign bus.oAvsAddress    = avs_addr_q;
  assign bus.oAvsByteenable = avs_be_q;
  assign bus.oAvsWritedata  = avs_wdata_q;
  assign bus.oAvsRead       = avs_read_q;
  assign bus.oAvsWrite      = avs_write_q;

endmodule
